pmux_rr_sched: RTL
==================

Name: pmux_rr_sched

Overview:
- Round-robin scheduler that shares the 4-bit one-hot-select priority mux (default lane plus three data lanes) among three requesters.
- Generates the one-hot 3-bit lane select (001/010/100, 000 = default lane) consumed by the mux.
- Registers the selected lane onto a valid/ready output stream and grants each requester bursts of up to BURST beats.
- Sits between the requesting producers and the downstream consumer of the muxed 4-bit word.

Parameters:
- W, 4, lane data width.
- BURST, 4, maximum beats per grant (must be ≥1; counter width $clog2(BURST)+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  3  per-requester valid; bit i = lane i.
- req_data  input  3*W  lane i at bits [W*i +: W] (lane0 = bits W-1:0).
- req_ready  output  3  per-requester ready; at most one bit set.
- dflt_data  input  W  default-lane word, selected when no grant.
- sel  output  3  one-hot lane select to the mux; 000 = default lane.
- out_data  output  W  registered output word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream ready.
- out_src  output  2  lane index of the current out_data; 3 = default.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE, ptr = 0, g = 0, beat_cnt = 0.
  - sel = 000, req_ready = 000.
  - out_valid = 0, out_data = 0, out_src = 3.
- State IDLE:
  - sel = 000, req_ready = 000.
  - If any req_valid: pick the first set bit scanning ptr, ptr+1, ptr+2 (mod 3). Register g; beat_cnt <= 0; next = GRANT.
  - Arbitration costs exactly 1 cycle. No transfer occurs in IDLE.
- State GRANT:
  - sel = onehot(g), registered. It changes only on state transitions, so the mux select never glitches mid-grant.
  - req_ready[g] = out_ready | ~out_valid. This is combinational, with no skid buffer. All other req_ready bits are 0.
  - Transfer when req_valid[g] & req_ready[g]:
    - out_data <= lane g, out_src <= g, out_valid <= 1.
    - beat_cnt <= beat_cnt+1.
  - Release to IDLE with ptr <= (g+1) mod 3 when either:
    - a transfer occurs with beat_cnt == BURST-1, or
    - req_valid[g] == 0 in a GRANT cycle. An idle requester forfeits the remainder of its burst.
  - Backpressure (req_valid[g]=1 and req_ready[g]=0) holds GRANT; beat_cnt is unchanged; no release.
- Output register, when no transfer this cycle:
  - If out_ready=1 or out_valid=0: out_valid <= 0, out_data <= dflt_data, out_src <= 3. The idle output tracks the default lane with a 1-cycle lag.
  - Otherwise: hold all output fields.
  - A transfer and a drain in the same cycle give back-to-back beats: full throughput of 1 beat/cycle within a burst.
- Fairness: ptr advances only on release. A requester that keeps valid high is served again after at most two other bursts.
- Latency: from req_valid rising (sched IDLE) to first beat on out_valid is 2 cycles (arbitrate, then transfer).
- Reset mid-burst: all state clears next edge. An in-flight out_valid word is dropped. Requesters see req_ready=0 from the reset cycle onward.
- BURST=1: every transfer releases. The pattern alternates GRANT/IDLE, so throughput is 1 beat per 2 cycles per requester.

Test Plan:
- Reset default path: rst 1 cycle, then dflt_data=4'hA with no requests.
  - Expect out_valid=0, sel=000, out_src=3.
  - Expect out_data=4'hA one cycle after dflt_data is applied.
- Single requester burst: lane1 valid continuously with data 1,2,3,4,5, out_ready=1, BURST=4.
  - Expect sel=010, out_data 1,2,3,4 on consecutive cycles.
  - Then one IDLE cycle (sel=000), re-grant, out_data 5.
- Round-robin rotation: all three lanes valid continuously (lane0=4'h1, lane1=4'h2, lane2=4'h3), BURST=2, out_ready=1.
  - Expect grant order 0,1,2,0.
  - Expect 2 beats per grant and sel sequence 001,000,010,000,100,000,001.
- Backpressure: lane2 granted, out_ready=0 for 3 cycles after the first beat (out_data=4'h7).
  - Expect out_data held at 7 and req_ready=000.
  - Expect beat_cnt held and sel held at 100.
  - Transfers resume on the cycle out_ready=1.
- Early release: lane0 granted, deasserts req_valid after 1 beat with BURST=4; lane1 valid.
  - Expect release to IDLE, ptr=1, and lane1 granted next (sel=010).
- Reset mid-burst: assert rst while out_valid=1 and sel=001.
  - Next cycle expect out_valid=0, sel=000, req_ready=000.
  - First post-reset grant goes to lane0 if it is valid (ptr=0).

Source files
------------

// File: rtl/pmux_rr_sched.sv
// Round-robin scheduler for a 3-lane + default one-hot priority mux.
// Grants one requester at a time for bursts of up to BURST beats and
// registers the selected lane onto a valid/ready output stream.
module pmux_rr_sched #(
  parameter int W     = 4,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     req_valid,
  input  logic [3*W-1:0] req_data,
  output logic [2:0]     req_ready,
  input  logic [W-1:0]   dflt_data,
  output logic [2:0]     sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     out_src
);
  localparam int            CW   = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    g_q, g_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [W-1:0]  od_q, od_d;
  logic          ov_q, ov_d;
  logic [1:0]    os_q, os_d;

  logic [1:0]    win;
  logic [2:0]    scan;
  logic [W-1:0]  g_data;
  logic          g_valid, can_acc, xfer, release_g;

  // Rotating-priority pick: scan ptr+2 down to ptr so the nearest lane wins last
  always_comb begin
    win  = ptr_q;
    scan = '0;
    for (int i = 2; i >= 0; i--) begin
      scan = {1'b0, ptr_q} + 3'(i);
      if (scan >= 3'd3) scan = scan - 3'd3;
      if (req_valid[scan[1:0]]) win = scan[1:0];
    end
  end

  // Granted lane word, selected through the registered one-hot select
  always_comb begin
    g_data = '0;
    for (int i = 0; i < 3; i++)
      if (sel_q[i]) g_data = req_data[W*i +: W];
  end

  // sel_q is non-zero only in GRANT, so it doubles as the grant qualifier
  assign g_valid   = |(req_valid & sel_q);
  assign can_acc   = (state_q == GRANT) && (out_ready || !ov_q) && !rst;
  assign xfer      = can_acc && g_valid;
  assign release_g = (state_q == GRANT) && (!g_valid || (xfer && cnt_q == LAST));

  // Per-lane ready: only the granted lane sees the output register's space
  for (genvar i = 0; i < 3; i++) begin : g_rdy
    assign req_ready[i] = can_acc & sel_q[i];
  end

  // Next-state: arbitration, burst accounting, output register update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    od_d    = od_q;
    ov_d    = ov_q;
    os_d    = os_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = GRANT;
          g_d     = win;
          cnt_d   = '0;
          sel_d   = 3'b001 << win;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = cnt_q + CW'(1);
        if (release_g) begin
          state_d = IDLE;
          ptr_d   = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;
          sel_d   = 3'b000;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      od_d = g_data;
      ov_d = 1'b1;
      os_d = g_q;
    end else if (out_ready || !ov_q) begin
      od_d = dflt_data;
      ov_d = 1'b0;
      os_d = 2'd3;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      os_q    <= 2'd3;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      os_q    <= os_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = od_q;
  assign out_valid = ov_q;
  assign out_src   = os_q;
endmodule
